// File: rtl/c17_key_loader.sv
// Serial key loader for the key-locked c17 netlist: shifts a key in MSB first and applies it atomically to D.
// Optional macro KEY_ALLOW_CHECK_EN enables the allowed-key check, failure counter and LOCKOUT state.
module c17_key_loader #(
   parameter int unsigned KEY_W   = 2,
   parameter int unsigned MAX_ERR = 3
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             KEY_START,
   input  logic             KEY_VLD,
   input  logic             KEY_SI,
   output logic             KEY_RDY,
   output logic [KEY_W-1:0] D,
   output logic             KEY_OK,
   output logic             KEY_ERR,
   output logic [3:0]       ERR_CNT,
   output logic             LOCKOUT
);

   localparam int unsigned CNT_W = $clog2(KEY_W + 1);

`ifdef KEY_ALLOW_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_LOCK} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_e;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_W-1:0]   shadow_q, shadow_d;
   logic [KEY_W-1:0]   d_q, d_d;
   logic               ok_q, ok_d;
   logic               rdy_q, rdy_d;

`ifdef KEY_ALLOW_CHECK_EN
   logic               err_q, err_d;
   logic [3:0]         errcnt_q, errcnt_d;
   logic               lock_q, lock_d;
   logic               allowed;

   assign allowed = (shadow_q == '0) || (shadow_q == '1);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      d_d      = d_q;
      ok_d     = 1'b0;
`ifdef KEY_ALLOW_CHECK_EN
      err_d    = 1'b0;
      errcnt_d = errcnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (KEY_START) begin
               state_d  = S_SHIFT;
               cnt_d    = '0;
               shadow_d = '0;
            end
         end
         S_SHIFT: begin
            // Restart wins over a valid bit in the same cycle; that bit is dropped.
            if (KEY_START) begin
               cnt_d    = '0;
               shadow_d = '0;
            end else if (KEY_VLD) begin
               shadow_d = {shadow_q[KEY_W-2:0], KEY_SI};
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(KEY_W)) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
`ifdef KEY_ALLOW_CHECK_EN
            if (allowed) begin
               d_d     = shadow_q;
               ok_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               err_d = 1'b1;
               if (errcnt_q != 4'hF) begin
                  errcnt_d = errcnt_q + 4'd1;
               end
               state_d = (errcnt_d >= 4'(MAX_ERR)) ? S_LOCK : S_IDLE;
            end
`else
            d_d     = shadow_q;
            ok_d    = 1'b1;
            state_d = S_IDLE;
`endif
         end
`ifdef KEY_ALLOW_CHECK_EN
         S_LOCK: begin
            state_d = S_LOCK;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Ready is held low for the pulse cycle that follows CHECK, then reflects IDLE.
      rdy_d = (state_d == S_IDLE) && (state_q != S_CHECK);
`ifdef KEY_ALLOW_CHECK_EN
      lock_d = (state_d == S_LOCK);
`endif
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         d_q      <= '0;
         ok_q     <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         d_q      <= d_d;
         ok_q     <= ok_d;
         rdy_q    <= rdy_d;
      end
   end

`ifdef KEY_ALLOW_CHECK_EN
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         err_q    <= 1'b0;
         errcnt_q <= '0;
         lock_q   <= 1'b0;
      end else begin
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
         lock_q   <= lock_d;
      end
   end

   assign KEY_ERR = err_q;
   assign ERR_CNT = errcnt_q;
   assign LOCKOUT = lock_q;
`else
   assign KEY_ERR = 1'b0;
   assign ERR_CNT = '0;
   assign LOCKOUT = 1'b0;
`endif

   assign KEY_RDY = rdy_q;
   assign D       = d_q;
   assign KEY_OK  = ok_q;

endmodule

// File: tb/tb_c17_key_loader.sv
// Directed self-checking bench for c17_key_loader (KEY_W=2, MAX_ERR=3); honours KEY_ALLOW_CHECK_EN.
module tb_c17_key_loader;

`ifdef KEY_ALLOW_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       CK = 1'b0;
   logic       RST = 1'b1;
   logic       KEY_START = 1'b0;
   logic       KEY_VLD = 1'b0;
   logic       KEY_SI = 1'b0;
   logic       KEY_RDY;
   logic [1:0] D;
   logic       KEY_OK;
   logic       KEY_ERR;
   logic [3:0] ERR_CNT;
   logic       LOCKOUT;

   int n_assert = 0;
   int n_fail   = 0;

   c17_key_loader #(.KEY_W(2), .MAX_ERR(3)) dut (
      .CK(CK), .RST(RST), .KEY_START(KEY_START), .KEY_VLD(KEY_VLD), .KEY_SI(KEY_SI),
      .KEY_RDY(KEY_RDY), .D(D), .KEY_OK(KEY_OK), .KEY_ERR(KEY_ERR),
      .ERR_CNT(ERR_CNT), .LOCKOUT(LOCKOUT)
   );

   always #5 CK = ~CK;

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues a full load; returns just after the edge where CHECK results appear.
   task automatic do_load(input logic [1:0] k, input logic [1:0] dprev);
      KEY_START = 1'b1;
      step();
      chk("rdy_after_start", 4'(KEY_RDY), 4'd0);
      KEY_START = 1'b0;
      KEY_VLD   = 1'b1;
      KEY_SI    = k[1];
      step();
      chk("d_hold_bit1", 4'(D), 4'(dprev));
      KEY_SI = k[0];
      step();
      chk("d_hold_bit2", 4'(D), 4'(dprev));
      chk("ok_not_early", 4'(KEY_OK), 4'd0);
      KEY_VLD = 1'b0;
      KEY_SI  = 1'b0;
      step();
   endtask

   initial begin
      #12 RST = 1'b0;
      repeat (5) step();
      chk("rst_d", 4'(D), 4'd0);
      chk("rst_rdy", 4'(KEY_RDY), 4'd1);
      chk("rst_ok", 4'(KEY_OK), 4'd0);
      chk("rst_err", 4'(KEY_ERR), 4'd0);
      chk("rst_errcnt", ERR_CNT, 4'd0);
      chk("rst_lock", 4'(LOCKOUT), 4'd0);

      // Load 11: accepted in both builds
      do_load(2'b11, 2'b00);
      chk("l11_ok", 4'(KEY_OK), 4'd1);
      chk("l11_err", 4'(KEY_ERR), 4'd0);
      chk("l11_d", 4'(D), 4'd3);
      chk("l11_rdy_low", 4'(KEY_RDY), 4'd0);
      step();
      chk("l11_ok_gone", 4'(KEY_OK), 4'd0);
      chk("l11_rdy", 4'(KEY_RDY), 4'd1);

      // Load 01: rejected with check, applied without
      do_load(2'b01, 2'b11);
      chk("l01_ok", 4'(KEY_OK), CHK ? 4'd0 : 4'd1);
      chk("l01_err", 4'(KEY_ERR), CHK ? 4'd1 : 4'd0);
      chk("l01_d", 4'(D), CHK ? 4'd3 : 4'd1);
      chk("l01_errcnt", ERR_CNT, CHK ? 4'd1 : 4'd0);
      step();
      chk("l01_err_gone", 4'(KEY_ERR), 4'd0);
      chk("l01_rdy", 4'(KEY_RDY), 4'd1);
      chk("l01_lock", 4'(LOCKOUT), 4'd0);

      // Stalled shift then restart: stale leading 1 must be dropped
      KEY_START = 1'b1;
      step();
      KEY_START = 1'b0;
      KEY_VLD   = 1'b1;
      KEY_SI    = 1'b1;
      step();
      KEY_VLD = 1'b0;
      repeat (3) begin
         step();
         chk("stall_ok", 4'(KEY_OK), 4'd0);
      end
      KEY_START = 1'b1;
      KEY_VLD   = 1'b1;
      KEY_SI    = 1'b1;
      step();
      KEY_START = 1'b0;
      KEY_SI    = 1'b0;
      step();
      chk("rs_ok_early", 4'(KEY_OK), 4'd0);
      step();
      chk("rs_ok_early2", 4'(KEY_OK), 4'd0);
      KEY_VLD = 1'b0;
      step();
      chk("rs_ok", 4'(KEY_OK), 4'd1);
      chk("rs_d", 4'(D), 4'd0);
      step();

      // Reset in the middle of a shift after D=11
      do_load(2'b11, 2'b00);
      chk("pre_rst_d", 4'(D), 4'd3);
      step();
      KEY_START = 1'b1;
      step();
      KEY_START = 1'b0;
      KEY_VLD   = 1'b1;
      KEY_SI    = 1'b0;
      step();
      #2 RST = 1'b1;
      #1;
      chk("arst_d", 4'(D), 4'd0);
      chk("arst_errcnt", ERR_CNT, 4'd0);
      chk("arst_rdy", 4'(KEY_RDY), 4'd1);
      #2 RST = 1'b0;
      KEY_VLD = 1'b0;
      step();
      step();
      chk("post_rst_rdy", 4'(KEY_RDY), 4'd1);
      chk("post_rst_d", 4'(D), 4'd0);

      // Lockout: D=11, then three rejected 10 keys
      do_load(2'b11, 2'b00);
      step();
      do_load(2'b10, 2'b11);
      chk("lk1_errcnt", ERR_CNT, CHK ? 4'd1 : 4'd0);
      chk("lk1_lock", 4'(LOCKOUT), 4'd0);
      step();
      do_load(2'b10, CHK ? 2'b11 : 2'b10);
      chk("lk2_errcnt", ERR_CNT, CHK ? 4'd2 : 4'd0);
      chk("lk2_lock", 4'(LOCKOUT), 4'd0);
      step();
      do_load(2'b10, CHK ? 2'b11 : 2'b10);
      chk("lk3_err", 4'(KEY_ERR), CHK ? 4'd1 : 4'd0);
      chk("lk3_errcnt", ERR_CNT, CHK ? 4'd3 : 4'd0);
      chk("lk3_lock", 4'(LOCKOUT), CHK ? 4'd1 : 4'd0);
      step();
      chk("lk3_rdy", 4'(KEY_RDY), CHK ? 4'd0 : 4'd1);
      chk("lk3_err_gone", 4'(KEY_ERR), 4'd0);

      // Load of 00 after lockout is ignored when checking is built in
      do_load(2'b00, CHK ? 2'b11 : 2'b10);
      chk("lk_ign_ok", 4'(KEY_OK), CHK ? 4'd0 : 4'd1);
      chk("lk_ign_d", 4'(D), CHK ? 4'd3 : 4'd0);
      step();
      chk("lk_ign_rdy", 4'(KEY_RDY), CHK ? 4'd0 : 4'd1);
      chk("lk_ign_errcnt", ERR_CNT, CHK ? 4'd3 : 4'd0);
      chk("lk_ign_lock", 4'(LOCKOUT), CHK ? 4'd1 : 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
